// File: rtl/game_strobe_scheduler.sv
// game_strobe_scheduler: per-channel divided base tick, queued and issued one grant per clock via round-robin
module game_strobe_scheduler #(
  parameter int n_req = 4,
  parameter int div_width = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         strobe_in,
  input  logic [n_req-1:0]             enable,
  input  logic [n_req*div_width-1:0]   period,
  input  logic                         clear_missed,
  output logic [n_req-1:0]             strobe_out,
  output logic [n_req-1:0]             missed
);
  localparam int lw = $clog2(n_req);
  logic [div_width-1:0] cnt_q [n_req];
  logic [div_width-1:0] cnt_d [n_req];
  logic [n_req-1:0] pending_q, pending_d, missed_q, missed_d, strobe_q, due, grant;
  logic [lw-1:0] last_q, last_d;
  assign strobe_out = strobe_q;
  assign missed = missed_q;
  always_comb begin
    grant = '0;
    last_d = last_q;
    for (int k = 1; k <= n_req; k++) begin
      if (grant == '0 && pending_q[(int'(last_q) + k) % n_req]) begin
        grant[(int'(last_q) + k) % n_req] = 1'b1;
        last_d = lw'((int'(last_q) + k) % n_req);
      end
    end
  end
  // A due event coinciding with its own grant re-arms pending instead of counting as a miss.
  always_comb begin
    for (int i = 0; i < n_req; i++) begin
      due[i] = strobe_in & enable[i] & (cnt_q[i] == '0);
      cnt_d[i] = !enable[i] ? '0 :
                 !strobe_in ? cnt_q[i] :
                 due[i] ? period[i*div_width +: div_width] : cnt_q[i] - 1'b1;
      pending_d[i] = enable[i] & (due[i] | (pending_q[i] & ~grant[i]));
      missed_d[i] = (due[i] & pending_q[i] & ~grant[i]) | (missed_q[i] & ~clear_missed);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      pending_q <= '0;
      missed_q <= '0;
      strobe_q <= '0;
      last_q <= lw'(n_req - 1);
    end else begin
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      missed_q <= missed_d;
      strobe_q <= grant;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_game_strobe_scheduler.sv
// tb_game_strobe_scheduler: table-driven per-cycle vectors with a scoreboard queue of expected outputs
module tb_game_strobe_scheduler;
  typedef struct {
    string       name;
    logic        r;
    logic        s;
    logic        c;
    logic [3:0]  e;
    logic [15:0] p;
    logic [3:0]  so;
    logic [3:0]  m;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic strobe_in = 1'b0;
  logic clear_missed = 1'b0;
  logic [3:0] enable = '0;
  logic [15:0] period = '0;
  logic [3:0] strobe_out, missed;
  int checks = 0;
  int failures = 0;
  vec_t v[$];
  vec_t sb[$];
  game_strobe_scheduler #(.n_req(4), .div_width(4)) dut (
    .clk(clk), .rst(rst), .strobe_in(strobe_in), .enable(enable), .period(period),
    .clear_missed(clear_missed), .strobe_out(strobe_out), .missed(missed)
  );
  always #5 clk = ~clk;
  function automatic void add(string n, logic r, logic s, logic c, logic [3:0] e,
                              logic [15:0] p, logic [3:0] so, logic [3:0] m);
    vec_t t;
    t.name = n; t.r = r; t.s = s; t.c = c; t.e = e; t.p = p; t.so = so; t.m = m;
    v.push_back(t);
  endfunction
  initial begin
    vec_t x;
    add("rst", 1, 0, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++) add("idle", 0, 0, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    add("a_tick", 0, 1, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    add("a_rr0", 0, 0, 0, 4'hF, 16'h0000, 4'h1, 4'h0);
    add("a_rr1", 0, 0, 0, 4'hF, 16'h0000, 4'h2, 4'h0);
    add("a_rr2", 0, 0, 0, 4'hF, 16'h0000, 4'h4, 4'h0);
    add("a_rr3", 0, 0, 0, 4'hF, 16'h0000, 4'h8, 4'h0);
    add("a_done", 0, 0, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++)
      add("b_div4", 0, 1, 0, 4'h2, 16'h0030, (i % 4 == 1) ? 4'h2 : 4'h0, 4'h0);
    add("c_rst", 1, 0, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    add("c_tick", 0, 1, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    add("c_miss", 0, 1, 0, 4'hF, 16'h0000, 4'h1, 4'hE);
    for (int i = 1; i < 8; i++)
      add("c_rr", 0, 1, 0, 4'hF, 16'h0000, 4'(1 << (i % 4)), 4'hF);
    add("d_clear", 0, 0, 1, 4'hF, 16'h0000, 4'h1, 4'h0);
    add("d_drain", 0, 0, 0, 4'hF, 16'h0000, 4'h2, 4'h0);
    add("d_drain", 0, 0, 0, 4'hF, 16'h0000, 4'h4, 4'h0);
    add("d_drain", 0, 0, 0, 4'hF, 16'h0000, 4'h8, 4'h0);
    add("d_empty", 0, 0, 0, 4'hF, 16'h0000, 4'h0, 4'h0);
    add("e_rst", 1, 0, 0, 4'h4, 16'h0000, 4'h0, 4'h0);
    add("e_tick", 0, 1, 0, 4'h4, 16'h0000, 4'h0, 4'h0);
    add("e_same", 0, 1, 0, 4'h4, 16'h0000, 4'h4, 4'h0);
    add("e_again", 0, 0, 0, 4'h4, 16'h0000, 4'h4, 4'h0);
    add("e_end", 0, 0, 0, 4'h4, 16'h0000, 4'h0, 4'h0);
    add("g_rst", 1, 0, 0, 4'h3, 16'h0000, 4'h0, 4'h0);
    add("g_tick", 0, 1, 0, 4'h3, 16'h0000, 4'h0, 4'h0);
    add("g_miss1", 0, 1, 0, 4'h3, 16'h0000, 4'h1, 4'h2);
    add("g_clrwin", 0, 1, 1, 4'h3, 16'h0000, 4'h2, 4'h1);
    add("g_hold", 0, 0, 0, 4'h3, 16'h0000, 4'h1, 4'h1);
    add("g_hold", 0, 0, 0, 4'h3, 16'h0000, 4'h2, 4'h1);
    add("g_end", 0, 0, 0, 4'h3, 16'h0000, 4'h0, 4'h1);
    add("f_tick", 0, 1, 0, 4'h7, 16'h0000, 4'h0, 4'h1);
    add("f_rst", 1, 0, 0, 4'h7, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) add("f_quiet", 0, 0, 0, 4'h7, 16'h0000, 4'h0, 4'h0);
    add("f_tick2", 0, 1, 0, 4'h7, 16'h0000, 4'h0, 4'h0);
    add("f_first0", 0, 0, 0, 4'h7, 16'h0000, 4'h1, 4'h0);
    add("f_next1", 0, 0, 0, 4'h7, 16'h0000, 4'h2, 4'h0);
    add("f_next2", 0, 0, 0, 4'h7, 16'h0000, 4'h4, 4'h0);
    add("f_end", 0, 0, 0, 4'h7, 16'h0000, 4'h0, 4'h0);
    foreach (v[i]) begin
      @(negedge clk);
      rst = v[i].r;
      strobe_in = v[i].s;
      clear_missed = v[i].c;
      enable = v[i].e;
      period = v[i].p;
      sb.push_back(v[i]);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if (strobe_out !== x.so) begin
        failures++;
        $display("FAIL %s row %0d strobe_out got %b want %b", x.name, i, strobe_out, x.so);
      end
      checks++;
      if (missed !== x.m) begin
        failures++;
        $display("FAIL %s row %0d missed got %b want %b", x.name, i, missed, x.m);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_strobe_scheduler.md
# game_strobe_scheduler

Distributes a single free-running base tick (one-cycle pulse from the game strobe generator) to up to `n_req` game objects, each at its own programmable rate. It divides the tick per channel, queues due events, and issues them one per clock through a round-robin arbiter, so that at most one sprite update fires in any cycle. It sits between the strobe generator and the sprite/movement logic, and is the only consumer of the base strobe.

## Interface
- `n_req`, 4: number of requesters/channels (2..8).
- `div_width`, 4: width of each per-channel period field.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `strobe_in`  in  1  base tick; one-cycle pulse, any spacing (may be high on consecutive cycles).
- `enable`  in  `n_req`  per-channel enable, level.
- `period`  in  `n_req*div_width`  channel i field `[i*div_width +: div_width]`; channel fires once every `period_i+1` base ticks.
- `clear_missed`  in  1  pulse; clears all `missed` bits.
- `strobe_out`  out  `n_req`  registered, one-hot-or-zero, one-cycle grant pulse per channel.
- `missed`  out  `n_req`  sticky flag: a due event was dropped for that channel.

## Operation
- Per channel i: down-counter `cnt_i` (`div_width` bits), `pending_i` bit, `missed_i` bit.
- The channel's "due" condition is `strobe_in & enable_i & (cnt_i == 0)`.
- On `strobe_in & enable_i`:
  - if `cnt_i == 0`, due; `cnt_i <= period_i`.
  - otherwise `cnt_i <= cnt_i - 1`.
  - `period_i` is sampled only at reload; changing it mid-count takes effect on the next reload.
- `enable_i == 0`: `cnt_i <= 0` and `pending_i <= 0`. `missed_i` is untouched. Re-enabling makes the channel due on the first subsequent `strobe_in`.
- Pending update each cycle, with `grant_i` = channel i selected this cycle:
  - due sets `pending_i`; grant clears it.
  - If due and grant occur in the same cycle for the same channel, `pending_i` stays 1 and `missed` is not set.
  - If due occurs while `pending_i == 1` and there is no grant this cycle, the event is dropped and `missed_i <= 1`.
- Arbiter:
  - Combinational round-robin over `pending`, searching from `last_grant+1` (mod `n_req`) upward.
  - `strobe_out <= grant` (registered). `last_grant` updates only when a grant is made.
- `clear_missed` clears all `missed` bits. If `clear_missed` and a new miss occur in the same cycle, the miss wins (bit ends at 1).
- `period_i == 0`: the channel is due on every enabled `strobe_in`.

## Timing
- Reset values: `cnt = 0`, `pending = 0`, `missed = 0`, `strobe_out = 0`, `last_grant = n_req-1` (so channel 0 has first priority).
- Latency:
  - Due at cycle t sets `pending` at t+1.
  - The grant is computed in t+1, and `strobe_out` is high during t+2 when uncontested (2 cycles from `strobe_in`).
- With k channels pending, each is served within k cycles. No channel waits more than `n_req` cycles after its `pending` is set.
- `strobe_out` is never multi-hot. Each bit is high for exactly one cycle per grant.
- Reset asserted mid-operation: on the next edge all state returns to reset values, and grants in flight are discarded (`strobe_out = 0` the cycle after reset).

## Test plan
- Reset, all enabled, `period = 0` for all, single `strobe_in` pulse at cycle 10:
  - required: `strobe_out` = 0001, 0010, 0100, 1000 in cycles 12..15.
  - required: `missed = 0`.
- Channel 1 only, `period_1 = 3`, `strobe_in` every cycle:
  - required: `strobe_out[1]` pulses every 4 cycles.
  - required: the first pulse comes 2 cycles after the first `strobe_in`.
- All channels enabled, `period = 0`, `strobe_in` held high continuously:
  - required: round-robin 0,1,2,3 repeating.
  - required: `missed` rises on each channel as its due events repeat while it is still pending and not granted.
- After the previous test, assert `clear_missed` with `strobe_in` low:
  - required: `missed = 0` next cycle.
- Same channel due and granted in the same cycle:
  - required: a second `strobe_out` pulse for that channel follows.
  - required: `missed` stays 0.
- Reset asserted the cycle after `strobe_in` with 3 channels pending:
  - required: no `strobe_out` pulses afterwards.
  - required: `last_grant` restarts so channel 0 is served first on the next tick.
